// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants and helpers for the timer bank: default
//               parameter values and the per-channel slice-index function.
//               Optional feature macro: TIMER_BANK_CAPTURE_EN
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Default channel count, channel width and prescaler width.
    localparam int c_DEF_NUM_CH        = 2;
    localparam int c_DEF_WIDTH         = 8;
    localparam int c_DEF_DIVIDER_WIDTH = 16;

    // Legal channel count range.
    localparam int c_MIN_NUM_CH = 1;
    localparam int c_MAX_NUM_CH = 16;

    // LSB index of channel 'ch' inside a packed per-channel bus of
    // 'width'-bit slices (channel 0 occupies the least-significant slice).
    function automatic int sliceLsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Shared prescaler. Emits a one-clock 'tick' once every
//               'divider' cycles; divider values 0 and 1 both mean "tick
//               every cycle". Lowering the divider below the current phase
//               forces an immediate tick and restarts the phase at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIVIDER_WIDTH = c_DEF_DIVIDER_WIDTH
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [DIVIDER_WIDTH-1:0] divider,
    output logic                     tick
);

    localparam logic [DIVIDER_WIDTH-1:0] c_ONE = DIVIDER_WIDTH'(1);

    logic [DIVIDER_WIDTH-1:0] r_phase;
    logic                     w_bypass;
    logic                     w_wrap;

    // divider <= 1 bypasses the prescaler entirely.
    assign w_bypass = (divider <= c_ONE);

    // '>=' rather than '==' so that shrinking the divider mid-period can
    // never leave the phase stranded above the new terminal value.
    assign w_wrap = (r_phase >= (divider - c_ONE));

    assign tick = w_bypass | w_wrap;

    // Phase counter: restarts at zero on every tick, otherwise advances.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_phase <= '0;
        end else if (tick) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_ONE;
        end
    end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank
// Description : Bank of NUM_CH independent up-counters sharing one
//               prescaler tick. Each channel counts on tick while enabled,
//               reloads initVal on reaching its compare value (raising
//               earlyMatch combinationally and match one clock later), and
//               can halt after the first match in one-shot mode.
//               Optional feature macro: TIMER_BANK_CAPTURE_EN adds a
//               per-channel capture strobe that snapshots the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bank
    import timer_pkg::*;
#(
    parameter int NUM_CH        = c_DEF_NUM_CH,
    parameter int WIDTH         = c_DEF_WIDTH,
    parameter int DIVIDER_WIDTH = c_DEF_DIVIDER_WIDTH
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic [DIVIDER_WIDTH-1:0]  divider,
    output logic                      tick,
    input  logic [NUM_CH-1:0]         inc,
    input  logic [NUM_CH-1:0]         clear,
    input  logic [NUM_CH-1:0]         oneShot,
    input  logic [NUM_CH*WIDTH-1:0]   compare,
    input  logic [NUM_CH*WIDTH-1:0]   initVal,
    output logic [NUM_CH*WIDTH-1:0]   counter,
    output logic [NUM_CH-1:0]         earlyMatch,
    output logic [NUM_CH-1:0]         match,
    output logic [NUM_CH-1:0]         done
`ifdef TIMER_BANK_CAPTURE_EN
    ,
    input  logic [NUM_CH-1:0]         capture,
    output logic [NUM_CH*WIDTH-1:0]   capVal
`endif
);

    localparam logic [WIDTH-1:0] c_CNT_ONE = WIDTH'(1);

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic w_tick;

    timer_prescaler #(
        .DIVIDER_WIDTH (DIVIDER_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .nReset  (nReset),
        .divider (divider),
        .tick    (w_tick)
    );

    assign tick = w_tick;

    // ------------------------------------------------------------------
    // Channels: identical, independent apart from the shared tick
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int c_LSB = sliceLsb(i, WIDTH);

        logic [WIDTH-1:0] r_count;
        logic             r_done;
        logic             r_match;
        logic [WIDTH-1:0] w_compare;
        logic [WIDTH-1:0] w_initVal;
        logic             w_step;
        logic             w_hit;
        logic             w_early;

        assign w_compare = compare[c_LSB +: WIDTH];
        assign w_initVal = initVal[c_LSB +: WIDTH];

        // A step needs the tick and the enable; a halted one-shot channel
        // and a clear both suppress it (clear wins over the terminal step).
        assign w_step  = inc[i] & w_tick & ~r_done & ~clear[i];
        assign w_hit   = (r_count == w_compare);
        assign w_early = w_step & w_hit;

        // Count, reload and one-shot halt state for this channel.
        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                r_count <= '0;
                r_done  <= 1'b0;
                r_match <= 1'b0;
            end else begin
                r_match <= w_early;
                if (clear[i]) begin
                    r_count <= w_initVal;
                    r_done  <= 1'b0;
                end else if (w_step) begin
                    // Non-matching steps wrap naturally at all-ones.
                    r_count <= w_hit ? w_initVal : (r_count + c_CNT_ONE);
                    if (w_hit && oneShot[i]) begin
                        r_done <= 1'b1;
                    end
                end
            end
        end

        assign counter[c_LSB +: WIDTH] = r_count;
        assign earlyMatch[i]           = w_early;
        assign match[i]                = r_match;
        assign done[i]                 = r_done;

`ifdef TIMER_BANK_CAPTURE_EN
        logic [WIDTH-1:0] r_capVal;

        // Snapshot of the counter value as it stood before this edge.
        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                r_capVal <= '0;
            end else if (capture[i]) begin
                r_capVal <= r_count;
            end
        end

        assign capVal[c_LSB +: WIDTH] = r_capVal;
`endif
    end : g_ch

endmodule : timer_bank
`default_nettype wire

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent counter channels (1..16).
REQ-002 Parameter WIDTH, default 8, counter/compare/initVal width per channel.
REQ-003 Parameter DIVIDER_WIDTH, default 16, width of shared prescaler divide factor.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 divider  input  DIVIDER_WIDTH  shared prescaler factor; 0 or 1 = divide by 1.
REQ-007 tick  output  1  one-clk pulse per prescaler period.
REQ-008 inc  input  NUM_CH  per-channel count enable.
REQ-009 clear  input  NUM_CH  per-channel synchronous reload to initVal and done clear.
REQ-010 oneShot  input  NUM_CH  1 = halt after compare match; 0 = periodic reload.
REQ-011 compare  input  NUM_CH*WIDTH  per-channel terminal value, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 initVal  input  NUM_CH*WIDTH  per-channel reload value, same packing.
REQ-013 counter  output  NUM_CH*WIDTH  per-channel registered count, same packing.
REQ-014 earlyMatch  output  NUM_CH  combinational, high in the cycle a terminal step occurs.
REQ-015 match  output  NUM_CH  registered, earlyMatch delayed one clk.
REQ-016 done  output  NUM_CH  registered, high while a one-shot channel is halted.

Function
REQ-017 Prescaler SHALL hold count p; divider<=1: tick=1 every cycle; else tick=1 when p==divider-1, then p<=0, otherwise p<=p+1.
REQ-018 If divider changes so p>=divider-1, tick SHALL assert in that cycle and p SHALL restart at 0.
REQ-019 step[i] SHALL equal inc[i] & tick & ~done[i] & ~clear[i].
REQ-020 On step[i] with counter[i]==compare[i], counter[i] SHALL load initVal[i] and earlyMatch[i] SHALL be 1 in that cycle.
REQ-021 On step[i] with counter[i]!=compare[i], counter[i] SHALL increment modulo 2^WIDTH (all-ones wraps to 0, no match).
REQ-022 On terminal step with oneShot[i]=1, done[i] SHALL set next cycle; further steps SHALL be blocked until clear[i].
REQ-023 clear[i] SHALL load counter[i]<=initVal[i], done[i]<=0, and take priority over a simultaneous step (no earlyMatch, no match).
REQ-024 match[i] SHALL be exactly earlyMatch[i] registered: single-cycle pulse, latency 1 clk.
REQ-025 Channels SHALL be fully independent except for the shared tick.
REQ-026 inc[i] low SHALL freeze counter[i]; the prescaler SHALL keep running regardless of inc.

Reset
REQ-027 nReset low SHALL asynchronously force counter=0, match=0, done=0, p=0, capVal=0 (if present); initVal is not applied at reset.
REQ-028 Reset mid-count SHALL abandon all state; the first tick after release SHALL occur divider-1 cycles after the first clk edge (every cycle if divider<=1).

Configuration
REQ-029 Macro TIMER_BANK_CAPTURE_EN SHALL, when defined, add inputs capture[NUM_CH] and outputs capVal[NUM_CH*WIDTH]; capture[i] high latches the pre-update counter[i] into capVal[i] next edge.
REQ-030 Without TIMER_BANK_CAPTURE_EN the capture ports and registers SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package timer_pkg SHALL hold default parameter constants and the channel slice-index helper function.
REQ-032 Prescaler SHALL be sub-module timer_prescaler (divider in, tick out, clk, nReset); channels SHALL be a generate loop in timer_bank.

Verification
REQ-033 divider=0, NUM_CH=2, ch0 inc=1, initVal=0, compare=3 -> counter 0,1,2,3,0; earlyMatch in the 3->0 cycle; match one cycle later.
REQ-034 divider=4, inc=1, compare=1 -> tick every 4th clk; counter changes only on tick cycles; match every 8 clks.
REQ-035 oneShot=1, compare=2, initVal=0 -> single match, done=1, counter held at 0 until clear; clear drops done and restarts.
REQ-036 clear and terminal step in same cycle -> counter=initVal, no earlyMatch, no match.
REQ-037 compare=0x05, initVal=0x10, inc=1, divider=1 -> counts 0x10..0xFF, wraps to 0x00 silently, matches at 0x05 and reloads 0x10.
REQ-038 nReset pulse mid-count with divider=3 (and capture=1 with TIMER_BANK_CAPTURE_EN) -> all outputs 0 immediately; capVal equals counter sampled the prior cycle after release.
